// File: rtl/retire_trace_if.sv
// retire_trace_if: writeback capture inputs and trace record outputs of the retire trace FIFO
interface retire_trace_if;
  logic        wb_valid;
  logic [15:0] wb_pc, wb_inst, wb_wdata, wb_memaddr, wb_memdata;
  logic        wb_regwrite, wb_memread, wb_memwrite, wb_halt;
  logic [2:0]  wb_wreg;
  logic        out_ready;
  logic        out_valid;
  logic [31:0] out_inum;
  logic [15:0] out_pc, out_inst, out_wdata, out_memaddr, out_memdata;
  logic [2:0]  out_wreg;
  logic        out_regwrite, out_memread, out_memwrite, out_halt;
  logic [31:0] inst_count, cycle_count;
  logic        halted, overflow, empty_after_halt;
  modport master (
    output wb_valid, wb_pc, wb_inst, wb_wdata, wb_memaddr, wb_memdata,
           wb_regwrite, wb_memread, wb_memwrite, wb_halt, wb_wreg, out_ready,
    input  out_valid, out_inum, out_pc, out_inst, out_wdata, out_memaddr, out_memdata,
           out_wreg, out_regwrite, out_memread, out_memwrite, out_halt,
           inst_count, cycle_count, halted, overflow, empty_after_halt
  );
  modport slave (
    input  wb_valid, wb_pc, wb_inst, wb_wdata, wb_memaddr, wb_memdata,
           wb_regwrite, wb_memread, wb_memwrite, wb_halt, wb_wreg, out_ready,
    output out_valid, out_inum, out_pc, out_inst, out_wdata, out_memaddr, out_memdata,
           out_wreg, out_regwrite, out_memread, out_memwrite, out_halt,
           inst_count, cycle_count, halted, overflow, empty_after_halt
  );
endinterface

// File: rtl/retire_trace_fifo.sv
// retire_trace_fifo: numbers each retiring instruction and buffers its record for the trace consumer
module retire_trace_fifo #(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3
) (
  input logic clk,
  input logic rst,
  retire_trace_if.slave bus
);
  typedef struct packed {
    logic [31:0] inum;
    logic [15:0] pc, inst, wdata, memaddr, memdata;
    logic [2:0]  wreg;
    logic        regwrite, memread, memwrite, halt;
  } rec_t;
  localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);
  rec_t             mem_q [DEPTH];
  rec_t             wrec, head;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic [31:0]      inst_count_q, inst_count_d, cycle_count_q, cycle_count_d;
  logic             halted_q, halted_d, overflow_q, overflow_d;
  logic             push, pop, wr, nonempty;
  always_comb begin
    nonempty      = count_q != '0;
    push          = bus.wb_valid & ~halted_q;
    pop           = nonempty & bus.out_ready;
    wr            = push & ((count_q != FULL) | pop);
    count_d       = count_q + (PTR_W+1)'(wr) - (PTR_W+1)'(pop);
    wr_ptr_d      = wr_ptr_q + PTR_W'(wr);
    rd_ptr_d      = rd_ptr_q + PTR_W'(pop);
    // a dropped record still consumes a number so the gap is visible downstream
    inst_count_d  = inst_count_q + 32'(push);
    cycle_count_d = cycle_count_q + 32'd1;
    halted_d      = halted_q | (push & bus.wb_halt);
    overflow_d    = overflow_q | (push & ~wr);
    wrec.inum     = inst_count_q;
    wrec.pc       = bus.wb_pc;
    wrec.inst     = bus.wb_inst;
    wrec.wdata    = bus.wb_wdata;
    wrec.memaddr  = bus.wb_memaddr;
    wrec.memdata  = bus.wb_memdata;
    wrec.wreg     = bus.wb_wreg;
    wrec.regwrite = bus.wb_regwrite;
    wrec.memread  = bus.wb_memread;
    wrec.memwrite = bus.wb_memwrite;
    wrec.halt     = bus.wb_halt;
    head          = nonempty ? mem_q[rd_ptr_q] : '0;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      inst_count_q  <= '0;
      cycle_count_q <= '0;
      halted_q      <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      inst_count_q  <= inst_count_d;
      cycle_count_q <= cycle_count_d;
      halted_q      <= halted_d;
      overflow_q    <= overflow_d;
    end
  end
  always_ff @(posedge clk)
    if (wr) mem_q[wr_ptr_q] <= wrec;
  assign bus.out_valid        = nonempty;
  assign bus.out_inum         = head.inum;
  assign bus.out_pc           = head.pc;
  assign bus.out_inst         = head.inst;
  assign bus.out_wdata        = head.wdata;
  assign bus.out_memaddr      = head.memaddr;
  assign bus.out_memdata      = head.memdata;
  assign bus.out_wreg         = head.wreg;
  assign bus.out_regwrite     = head.regwrite;
  assign bus.out_memread      = head.memread;
  assign bus.out_memwrite     = head.memwrite;
  assign bus.out_halt         = head.halt;
  assign bus.inst_count       = inst_count_q;
  assign bus.cycle_count      = cycle_count_q;
  assign bus.halted           = halted_q;
  assign bus.overflow         = overflow_q;
  assign bus.empty_after_halt = halted_q & ~nonempty;
endmodule

// File: tb/tb_retire_trace_fifo.sv
// tb_retire_trace_fifo: queue-based reference model with a negedge monitor that pops and compares records
module tb_retire_trace_fifo;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  retire_trace_if bus();
  retire_trace_fifo #(.DEPTH(8), .PTR_W(3)) dut (.clk(clk), .rst(rst), .bus(bus));
  typedef struct packed {
    logic [31:0] inum;
    logic [15:0] pc, inst, wdata, memaddr, memdata;
    logic [2:0]  wreg;
    logic        regwrite, memread, memwrite, halt;
  } rec_t;
  rec_t        exp_q[$];
  int unsigned seen_q[$];
  rec_t        got, nrec;
  int unsigned m_inst, m_cycle;
  bit          m_halt, m_ovf, m_push;
  int          checks = 0;
  int          errors = 0;
  assign got = {bus.out_inum, bus.out_pc, bus.out_inst, bus.out_wdata, bus.out_memaddr,
                bus.out_memdata, bus.out_wreg, bus.out_regwrite, bus.out_memread,
                bus.out_memwrite, bus.out_halt};
  task automatic check(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // reference: FIFO of records, a running number, sticky halt/overflow
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      exp_q.delete();
      m_inst = 0; m_cycle = 0; m_halt = 0; m_ovf = 0;
    end else begin
      m_cycle++;
      m_push = bus.wb_valid && !m_halt;
      if (m_push) begin
        nrec.inum = m_inst;
        nrec.pc = bus.wb_pc; nrec.inst = bus.wb_inst; nrec.wdata = bus.wb_wdata;
        nrec.memaddr = bus.wb_memaddr; nrec.memdata = bus.wb_memdata; nrec.wreg = bus.wb_wreg;
        nrec.regwrite = bus.wb_regwrite; nrec.memread = bus.wb_memread;
        nrec.memwrite = bus.wb_memwrite; nrec.halt = bus.wb_halt;
        if (exp_q.size() < 8) exp_q.push_back(nrec);
        else m_ovf = 1;
        m_inst++;
        if (bus.wb_halt) m_halt = 1;
      end
    end
  end
  always @(negedge clk) begin
    if (!rst) begin
      check("rst_valid", bus.out_valid, 0);
      check("rst_fields", got, 0);
      check("rst_inst_count", bus.inst_count, 0);
      check("rst_cycle_count", bus.cycle_count, 0);
      check("rst_flags", {bus.halted, bus.overflow}, 0);
    end else begin
      check("out_valid", bus.out_valid, exp_q.size() != 0);
      check("inst_count", bus.inst_count, m_inst);
      check("cycle_count", bus.cycle_count, m_cycle);
      check("halted", bus.halted, m_halt);
      check("overflow", bus.overflow, m_ovf);
      check("empty_after_halt", bus.empty_after_halt, m_halt && exp_q.size() == 0);
      if (exp_q.size() != 0) check("head_record", got, exp_q[0]);
      if (bus.out_valid && bus.out_ready) seen_q.push_back(bus.out_inum);
      if (exp_q.size() != 0 && bus.out_ready) void'(exp_q.pop_front());
    end
  end
  task automatic tick(int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask
  task automatic rand_fields();
    bus.wb_pc = 16'($urandom); bus.wb_inst = 16'($urandom); bus.wb_wdata = 16'($urandom);
    bus.wb_memaddr = 16'($urandom); bus.wb_memdata = 16'($urandom); bus.wb_wreg = 3'($urandom);
    bus.wb_regwrite = 1'($urandom); bus.wb_memread = 1'($urandom);
    bus.wb_memwrite = 1'($urandom); bus.wb_halt = 1'b0;
  endtask
  task automatic push(logic [15:0] pc);
    rand_fields();
    bus.wb_valid = 1'b1;
    bus.wb_pc = pc;
    tick();
  endtask
  task automatic idle(int n);
    bus.wb_valid = 1'b0;
    tick(n);
  endtask
  task automatic do_reset();
    rst = 1'b0;
    bus.wb_valid = 1'b0;
    bus.out_ready = 1'b0;
    tick(2);
    seen_q.delete();
    rst = 1'b1;
  endtask
  task automatic check_seen(string name, int n);
    check({name, "_count"}, seen_q.size(), n);
    for (int i = 0; i < n && i < seen_q.size(); i++) check({name, "_inum"}, seen_q[i], i);
  endtask
  initial begin
    rand_fields();
    bus.wb_valid = 1'b1;
    bus.out_ready = 1'b1;
    tick(3);
    check("reset_out_valid", bus.out_valid, 0);
    check("reset_inst_count", bus.inst_count, 0);
    check("reset_cycle_count", bus.cycle_count, 0);
    rst = 1'b1;
    idle(5);
    check("cycle_after_release", bus.cycle_count, 5);
    do_reset();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_fields();
      bus.wb_valid = 1'b1; bus.wb_pc = 16'(2 * i); bus.wb_regwrite = 1'b1; bus.wb_wreg = 3'(i + 1);
      tick();
    end
    idle(4);
    check("basic_inst_count", bus.inst_count, 3);
    check_seen("basic", 3);
    do_reset();
    bus.out_ready = 1'b1;
    push(16'h0100); idle(2); push(16'h0102); idle(3);
    check("bubble_inst_count", bus.inst_count, 2);
    check_seen("bubble", 2);
    do_reset();
    for (int i = 0; i < 9; i++) push(16'(4 * i));
    bus.wb_valid = 1'b0;
    check("full_overflow", bus.overflow, 1);
    check("full_inst_count", bus.inst_count, 9);
    check("full_out_valid", bus.out_valid, 1);
    bus.out_ready = 1'b1;
    idle(10);
    check_seen("full_drain", 8);
    do_reset();
    for (int i = 0; i < 8; i++) push(16'(i));
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) push(16'(i + 8));
    check("simul_overflow", bus.overflow, 0);
    check("simul_still_valid", bus.out_valid, 1);
    idle(10);
    check_seen("simul", 12);
    do_reset();
    rand_fields();
    bus.wb_valid = 1'b1; bus.wb_memwrite = 1'b1; bus.wb_memaddr = 16'h0010; bus.wb_memdata = 16'hBEEF;
    tick();
    rand_fields();
    bus.wb_pc = 16'h0006; bus.wb_halt = 1'b1;
    tick();
    push(16'h0008); push(16'h000A);
    bus.wb_valid = 1'b0;
    check("halt_halted", bus.halted, 1);
    check("halt_inst_count", bus.inst_count, 2);
    check("halt_not_empty", bus.empty_after_halt, 0);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 20 && !bus.empty_after_halt; i++) tick();
    check("halt_empty_after_halt", bus.empty_after_halt, 1);
    check_seen("halt", 2);
    do_reset();
    for (int c = 0; c < 400; c++) begin
      if (c == 200) begin
        bus.out_ready = 1'b0;
        rst = 1'b0;
        #1;
        check("midreset_out_valid", bus.out_valid, 0);
        tick(2);
        rst = 1'b1;
      end
      rand_fields();
      bus.wb_valid = ($urandom_range(0, 9) < 6);
      bus.wb_halt = ($urandom_range(0, 99) == 0);
      bus.out_ready = ($urandom_range(0, 1) == 1);
      tick();
    end
    bus.out_ready = 1'b1;
    idle(12);
    check("random_drained", bus.out_valid, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
